// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time.
// A registered 2-bit winner index drives a one-hot grant. A holder that reaches
// HOLD_MAX consecutive cycles is revoked and locked out until it drops its request.
// Every grant is followed by one idle cycle before the next grant can be issued.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16  // 0 = unlimited hold, 1..255 = cycle bound
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A holder is revoked at the edge where its hold counter reads HOLD_MAX-1,
  // which leaves the grant visible for exactly HOLD_MAX cycles.
  localparam bit         HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(HOLD_MAX - 1) : 8'hFF;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] lock_q, lock_d;
  logic       timeout_q, timeout_d;

  logic [3:0] elig;
  logic [3:0] elig_rot;  // elig_rot[k] = elig[ptr + k], so bit 0 has top priority
  logic [1:0] winner;
  logic       found;

  assign elig = req & ~lock_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign elig_rot[gi] = elig[ptr_q + 2'(gi)];
    end
  endgenerate

  // Pick the first eligible requester in search order ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (elig_rot[k]) begin
        winner = ptr_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

  // Next-state logic: issue from IDLE, then release / revoke / count in GRANT.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    // A requester that withdraws is always forgiven; revoke only sets bits whose
    // request is still high, so it never collides with this clear.
    lock_d     = lock_q & req;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d   = winner;
          hold_cnt_d = 8'd0;
          ptr_d      = winner + 2'd1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          state_d = IDLE;
        end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d          = IDLE;
          timeout_d        = 1'b1;
          lock_d[gnt_id_q] = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_id_q   <= 2'd0;
      hold_cnt_q <= 8'd0;
      lock_q     <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      lock_q     <= lock_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;
  assign gnt       = gnt_valid ? (4'b0001 << gnt_id_q) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (HOLD_MAX = 16, 4, 0) share one stimulus
// stream. A cycle-level reference model per instance pushes expected outputs into a
// scoreboard queue at each rising edge; a monitor pops and compares on falling edges.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_w     [3];
  logic [1:0] gnt_id_w  [3];
  logic       gnt_v_w   [3];
  logic       timeout_w [3];

  localparam int HM [3] = '{16, 4, 0};

  rr_arbiter4 #(.HOLD_MAX(16)) u_h16 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[0]), .gnt_id(gnt_id_w[0]), .gnt_valid(gnt_v_w[0]), .timeout(timeout_w[0])
  );
  rr_arbiter4 #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[1]), .gnt_id(gnt_id_w[1]), .gnt_valid(gnt_v_w[1]), .timeout(timeout_w[1])
  );
  rr_arbiter4 #(.HOLD_MAX(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[2]), .gnt_id(gnt_id_w[2]), .gnt_valid(gnt_v_w[2]), .timeout(timeout_w[2])
  );

  // Reference model: who holds the resource, for how many visible cycles so far,
  // where the round-robin search starts, and who is locked out.
  typedef struct {
    int       holder;  // -1 when nobody holds
    int       held;    // cycles the current grant has been visible
    int       ptr;
    bit [3:0] lock;
    int       last;
    bit       to;
  } model_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
    logic       to;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  model_t m [3];
  exp3_t  sbq [$];
  int     total;
  int     passed;

  function automatic model_t step(model_t s, int hm, logic r, logic [3:0] q);
    model_t n = s;
    n.to = 1'b0;
    if (r) begin
      n.holder = -1; n.held = 0; n.ptr = 0; n.lock = 4'b0; n.last = 0;
      return n;
    end
    for (int i = 0; i < 4; i++) if (!q[i]) n.lock[i] = 1'b0;
    if (s.holder < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c = (s.ptr + k) % 4;
        if (q[c] && !s.lock[c]) begin
          n.holder = c; n.last = c; n.held = 1; n.ptr = (c + 1) % 4;
          break;
        end
      end
    end else if (!q[s.holder]) begin
      n.holder = -1;
    end else if (hm != 0 && s.held == hm) begin
      n.holder = -1; n.to = 1'b1; n.lock[s.holder] = 1'b1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  function automatic exp_t expect_of(model_t s);
    exp_t e;
    e.gnt = (s.holder >= 0) ? 4'(1 << s.holder) : 4'b0000;
    e.id  = 2'(s.last);
    e.v   = (s.holder >= 0);
    e.to  = s.to;
    return e;
  endfunction

  task automatic chk(input string name, input int inst, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s hold_max=%0d t=%0t: got %b, expected %b", name, HM[inst], $time, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: sample the same inputs as the DUTs at each rising edge, queue expectations.
  initial begin
    exp3_t e;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        m[k] = step(m[k], HM[k], rst, req);
        e[k] = expect_of(m[k]);
      end
      sbq.push_back(e);
    end
  end

  // Monitor: outputs are registered, so compare on the falling edge.
  initial begin
    exp3_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("gnt",       k, gnt_w[k],              e[k].gnt);
          chk("gnt_id",    k, {2'b00, gnt_id_w[k]},  {2'b00, e[k].id});
          chk("gnt_valid", k, {3'b000, gnt_v_w[k]},  {3'b000, e[k].v});
          chk("timeout",   k, {3'b000, timeout_w[k]}, {3'b000, e[k].to});
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
  endtask

  // Requesters in base hold for hold_len cycles, then drop for one cycle.
  task automatic run_react(input logic [3:0] base, input int hold_len, input int n);
    logic [3:0] q;
    repeat (n) begin
      @(negedge clk);
      q = base;
      if (m[0].holder >= 0 && m[0].held >= hold_len) q[m[0].holder] = 1'b0;
      rst = 1'b0;
      req = q;
    end
  endtask

  initial begin
    logic [3:0] rq;
    total  = 0;
    passed = 0;
    for (int k = 0; k < 3; k++) begin
      m[k].holder = -1; m[k].held = 0; m[k].ptr = 0;
      m[k].lock = 4'b0; m[k].last = 0; m[k].to = 1'b0;
    end
    rst = 1'b1;
    req = 4'b1111;
    // Reset priority: three reset edges with all requests high.
    cyc(1'b1, 4'b1111);
    cyc(1'b1, 4'b1111);
    // Rotation.
    run_react(4'b1111, 3, 26);
    // Skip and wrap.
    cyc(1'b1, 4'b0000);
    cyc(1'b0, 4'b0001);
    run_react(4'b1001, 2, 12);
    // Timeout and lockout.
    cyc(1'b1, 4'b0000);
    repeat (12) cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0000);
    repeat (8) cyc(1'b0, 4'b0100);
    // Timeout with contention.
    cyc(1'b1, 4'b0000);
    cyc(1'b0, 4'b0100);
    repeat (20) cyc(1'b0, 4'b0110);
    // Unlimited hold then mid-grant reset.
    cyc(1'b1, 4'b0000);
    repeat (300) cyc(1'b0, 4'b0001);
    cyc(1'b1, 4'b0001);
    repeat (6) cyc(1'b0, 4'b0001);
    // Random traffic with sticky requests and occasional reset.
    rq = 4'b0000;
    repeat (600) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
      cyc(($urandom_range(0, 99) == 0), rq);
    end
    cyc(1'b0, 4'b0000);
    cyc(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
